// File: rtl/trng_batch_sequencer_if.sv
// Output word stream of the TRNG batch sequencer: valid/ready with a last-word marker.
interface trng_batch_sequencer_if;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/trng_batch_sequencer.sv
// Runs one TRNG batch on the compute core: load INS=18, wait for completion or timeout,
// capture the error flag, reload a neutral read command, then stream the batch out of BRAM.
module trng_batch_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  num_words,
    input  logic [9:0]  dst_base,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    output logic        trng_fail,
    output logic        timeout,
    trng_batch_sequencer_if.master stream,
    output logic [34:0] command_in,
    output logic        command_we0,
    output logic        command_we1,
    output logic [9:0]  address_ext,
    output logic [63:0] dina_ext,
    output logic        wea_ext,
    input  logic [63:0] doutb_ext,
    input  logic        done_ins_computation,
    input  logic        error_trng_reg
);
    localparam logic [4:0]  INS_TRNG    = 5'd18;
    localparam logic [4:0]  INS_NOP     = 5'd0;
    localparam logic [23:0] TIMEOUT_LIM = 24'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_TRNG,
        S_WAIT_DONE,
        S_CAP_ERR,
        S_LOAD_READ,
        S_STREAM,
        S_FINISH
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  n_reg, base_reg;
    logic [23:0] tmo_cnt_reg;
    logic        cfg_err_reg, trng_fail_reg, timeout_reg;
    logic [9:0]  rd_ptr_reg, out_idx_reg;
    logic        inflight_reg;
    logic        fifo_wr_ptr_reg, fifo_rd_ptr_reg;
    logic [1:0]  fifo_cnt_reg;

    logic        num_ok, start_ok, done_seen, tmo_hit;
    logic        fifo_empty, head_valid, head_last, accept, issue, fifo_push, fifo_pop;
    logic [63:0] head_data;

    assign num_ok    = (num_words != 10'd0) && (num_words <= 10'd512);
    assign start_ok  = (state_reg == S_IDLE) && start && num_ok;
    // A zero count marks the first WAIT_DONE cycle, where done may still reflect the old command.
    assign done_seen = done_ins_computation && (tmo_cnt_reg != 24'd0);
    assign tmo_hit   = (tmo_cnt_reg + 24'd1) == TIMEOUT_LIM;

    // The word read last cycle is presented straight from doutb_ext while the FIFO is empty,
    // so the in-flight read counts as occupancy for the issue throttle.
    assign fifo_empty = (fifo_cnt_reg == 2'd0);
    assign head_valid = !fifo_empty || inflight_reg;
    assign head_data  = !fifo_empty ? (fifo_rd_ptr_reg ? g_fifo[1].entry_reg : g_fifo[0].entry_reg)
                                    : doutb_ext;
    assign head_last  = head_valid && (out_idx_reg == (n_reg - 10'd1));
    assign accept     = head_valid && stream.m_ready;
    assign issue      = (state_reg == S_STREAM) && (rd_ptr_reg != n_reg)
                        && ((fifo_cnt_reg + {1'b0, inflight_reg}) < 2'd2);
    assign fifo_push  = inflight_reg && !(fifo_empty && accept);
    assign fifo_pop   = accept && !fifo_empty;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [63:0] entry_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (fifo_push && (fifo_wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= doutb_ext;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (start) state_next = num_ok ? S_LOAD_TRNG : S_FINISH;
            S_LOAD_TRNG: state_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (done_seen)    state_next = S_CAP_ERR;
                else if (tmo_hit) state_next = S_LOAD_READ;
            end
            S_CAP_ERR:   state_next = S_LOAD_READ;
            S_LOAD_READ: state_next = timeout_reg ? S_FINISH : S_STREAM;
            S_STREAM:    if (accept && head_last) state_next = S_FINISH;
            S_FINISH:    state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_reg != S_IDLE);
        done        = (state_reg == S_FINISH);
        command_we0 = 1'b0;
        command_in  = '0;
        case (state_reg)
            S_LOAD_TRNG: begin
                command_we0 = 1'b1;
                command_in  = {base_reg, 10'd0, n_reg, INS_TRNG};
            end
            S_LOAD_READ: begin
                command_we0 = 1'b1;
                command_in  = {10'd0, 10'd0, base_reg, INS_NOP};
            end
            default: ;
        endcase
        address_ext = (state_reg == S_STREAM) ? rd_ptr_reg : 10'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg           <= '0;
            base_reg        <= '0;
            tmo_cnt_reg     <= '0;
            cfg_err_reg     <= 1'b0;
            trng_fail_reg   <= 1'b0;
            timeout_reg     <= 1'b0;
            rd_ptr_reg      <= '0;
            out_idx_reg     <= '0;
            inflight_reg    <= 1'b0;
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_cnt_reg    <= '0;
        end else begin
            if (start_ok) begin
                n_reg         <= num_words;
                base_reg      <= dst_base;
                cfg_err_reg   <= 1'b0;
                trng_fail_reg <= 1'b0;
                timeout_reg   <= 1'b0;
                rd_ptr_reg    <= '0;
                out_idx_reg   <= '0;
            end else if ((state_reg == S_IDLE) && start) begin
                cfg_err_reg   <= 1'b1;
            end

            if (state_reg == S_LOAD_TRNG) begin
                tmo_cnt_reg <= '0;
            end else if (state_reg == S_WAIT_DONE) begin
                tmo_cnt_reg <= tmo_cnt_reg + 24'd1;
            end
            if ((state_reg == S_WAIT_DONE) && !done_seen && tmo_hit) begin
                timeout_reg <= 1'b1;
            end
            if (state_reg == S_CAP_ERR) begin
                trng_fail_reg <= error_trng_reg;
            end

            if (issue) rd_ptr_reg <= rd_ptr_reg + 10'd1;
            if (accept) out_idx_reg <= out_idx_reg + 10'd1;
            inflight_reg <= issue;
            if (fifo_push) fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
            if (fifo_pop) fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            fifo_cnt_reg <= fifo_cnt_reg + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    assign stream.m_valid = head_valid;
    assign stream.m_data  = head_valid ? head_data : 64'd0;
    assign stream.m_last  = head_last;

    assign cfg_err     = cfg_err_reg;
    assign trng_fail   = trng_fail_reg;
    assign timeout     = timeout_reg;
    assign command_we1 = 1'b0;
    assign dina_ext    = 64'd0;
    assign wea_ext     = 1'b0;
endmodule

// File: tb/tb_trng_batch_sequencer.sv
// Scoreboard bench: each batch pushes its expected commands and words; a negedge monitor checks them.
module tb_trng_batch_sequencer;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  num_words = '0;
    logic [9:0]  dst_base = '0;
    logic        busy, done, cfg_err, trng_fail, timeout;
    logic [34:0] command_in;
    logic        command_we0, command_we1, wea_ext;
    logic [9:0]  address_ext;
    logic [63:0] dina_ext;
    logic [63:0] doutb_ext = '0;
    logic        done_ins_computation = 1'b0;
    logic        error_trng_reg = 1'b0;

    trng_batch_sequencer_if sif();

    trng_batch_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words), .dst_base(dst_base),
        .busy(busy), .done(done), .cfg_err(cfg_err), .trng_fail(trng_fail), .timeout(timeout),
        .stream(sif), .command_in(command_in), .command_we0(command_we0),
        .command_we1(command_we1), .address_ext(address_ext), .dina_ext(dina_ext),
        .wea_ext(wea_ext), .doutb_ext(doutb_ext),
        .done_ins_computation(done_ins_computation), .error_trng_reg(error_trng_reg)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [63:0] data; logic last; } word_t;

    int          errors = 0, checks = 0, cyc = 0;
    int          done_pulses = 0, done_cyc = -1, cmd_strobes = 0;
    int          trng_cmd_cyc = -1, read_cmd_cyc = -1, first_valid_cyc = -1;
    int          core_latency = -1;
    bit          ready_random = 1'b0;
    bit          exp_cfg = 0, exp_fail = 0, exp_tmo = 0;
    logic [63:0] mem [1024];
    word_t       word_q[$];
    logic [34:0] cmd_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Core + BRAM model: completion after core_latency cycles, registered read at base+address.
    logic [9:0] rd_base = '0;
    bit         core_run = 1'b0;
    int         lat_cnt = 0;
    always @(posedge clk) begin
        doutb_ext <= mem[10'(rd_base + address_ext)];
        if (command_we0) begin
            done_ins_computation <= 1'b0;
            if (command_in[4:0] == 5'd18) begin
                core_run <= 1'b1;
                lat_cnt  <= 0;
            end else begin
                core_run <= 1'b0;
                rd_base  <= command_in[14:5];
            end
        end else if (core_run) begin
            lat_cnt <= lat_cnt + 1;
            if (core_latency >= 1 && lat_cnt + 1 >= core_latency) done_ins_computation <= 1'b1;
        end
    end

    initial begin
        sif.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            sif.m_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) begin
                done_pulses++;
                done_cyc = cyc;
            end
            if (command_we0) begin
                cmd_strobes++;
                if (command_in[4:0] == 5'd18) trng_cmd_cyc = cyc;
                else read_cmd_cyc = cyc;
                if (cmd_q.size() == 0) check("cmd_unexpected", 64'(command_in), 64'd0);
                else check("cmd_word", 64'(command_in), 64'(cmd_q.pop_front()));
            end
            if (sif.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid_hold", 64'(sif.m_valid), 64'd1);
                check("stall_data_hold", sif.m_data, prev_data);
            end
            if (sif.m_valid && sif.m_ready) begin
                if (word_q.size() == 0) begin
                    check("word_unexpected", sif.m_data, 64'd0);
                end else begin
                    word_t w;
                    w = word_q.pop_front();
                    check("word_data", sif.m_data, w.data);
                    check("word_last", 64'(sif.m_last), 64'(w.last));
                end
            end else if (sif.m_last && !sif.m_valid) begin
                check("last_without_valid", 64'(sif.m_last), 64'd0);
            end
            prev_stall = sif.m_valid && !sif.m_ready;
            prev_data  = sif.m_data;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_flags"}, 64'({cfg_err, trng_fail, timeout}), 64'd0);
        check({tag, "_stream"}, {sif.m_data[62:0], sif.m_valid}, 64'd0);
        check({tag, "_last"}, 64'(sif.m_last), 64'd0);
        check({tag, "_cmd"}, 64'({command_in, command_we0}), 64'd0);
        check({tag, "_addr"}, 64'(address_ext), 64'd0);
    endtask

    // lat < 1 means the core never completes; abort > 0 resets the DUT mid-stream.
    task automatic run_batch(input int n, input int base, input int lat, input bit err,
                             input bit rnd, input int abort);
        bit legal, tmo;
        int d0, c0, start_cyc;
        legal = (n >= 1 && n <= 512);
        tmo   = (lat < 1);
        core_latency   = lat;
        error_trng_reg = err;
        ready_random   = rnd;
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
        if (legal) begin
            cmd_q.push_back({10'(base), 10'd0, 10'(n), 5'd18});
            cmd_q.push_back({20'd0, 10'(base), 5'd0});
            if (!tmo)
                for (int i = 0; i < n; i++) word_q.push_back('{data: mem[10'(base + i)], last: (i == n - 1)});
            exp_cfg  = 0;
            exp_fail = tmo ? 1'b0 : err;
            exp_tmo  = tmo;
        end else begin
            exp_cfg = 1;
        end
        $display("batch n=%0d base=%0d latency=%0d err=%0d random_ready=%0d abort=%0d", n, base, lat, err, rnd, abort);
        d0 = done_pulses;
        c0 = cmd_strobes;
        first_valid_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        num_words = 10'(n);
        dst_base  = 10'(base);
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        num_words = 10'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        if (abort > 0) begin
            for (int k = 0; k < 5000 && word_q.size() > n - abort; k++) @(negedge clk);
            check("abort_reached_stream", 64'(word_q.size() <= n - abort), 64'd1);
            #2 rst = 1'b1;
            #1 check_all_zero("async_reset");
            check("abort_no_done", 64'(done_pulses - d0), 64'd0);
            word_q.delete();
            cmd_q.delete();
            exp_cfg = 0; exp_fail = 0; exp_tmo = 0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        for (int k = 0; k < 20000 && done_pulses == d0; k++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("done_pulse_count", 64'(done_pulses - d0), 64'd1);
        check("idle_after_run", 64'(busy), 64'd0);
        check("cfg_err", 64'(cfg_err), 64'(exp_cfg));
        check("trng_fail", 64'(trng_fail), 64'(exp_fail));
        check("timeout", 64'(timeout), 64'(exp_tmo));
        check("words_left", 64'(word_q.size()), 64'd0);
        check("cmds_left", 64'(cmd_q.size()), 64'd0);
        check("cmd_strobe_count", 64'(cmd_strobes - c0), legal ? 64'd2 : 64'd0);
        check("tied_outputs", {command_we1, wea_ext, dina_ext[61:0]}, 64'd0);
        if (!legal) begin
            check("reject_done_latency", 64'(done_cyc - start_cyc), 64'd1);
        end else if (tmo) begin
            check("timeout_wait_len", 64'(read_cmd_cyc - trng_cmd_cyc), 64'(TMO + 1));
            check("timeout_no_valid", 64'(first_valid_cyc < 0), 64'd1);
            check("timeout_done_after_read", 64'(done_cyc - read_cmd_cyc), 64'd1);
        end else begin
            check("trng_cmd_cycle", 64'(trng_cmd_cyc - start_cyc), 64'd1);
            check("done_to_read_cmd", 64'(read_cmd_cyc - trng_cmd_cyc), 64'(lat + 3));
            check("read_cmd_to_valid", 64'(first_valid_cyc - read_cmd_cyc), 64'd2);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_batch(4, 16, 50, 1'b0, 1'b0, 0);
        run_batch(512, 0, 20, 1'b0, 1'b1, 0);
        run_batch(7, 1020, 10, 1'b1, 1'b1, 0);
        run_batch(5, 300, 30, 1'b0, 1'b1, 0);
        run_batch(3, 40, -1, 1'b0, 1'b0, 0);
        run_batch(0, 8, 5, 1'b0, 1'b0, 0);
        run_batch(600, 8, 5, 1'b0, 1'b0, 0);
        for (int r = 0; r < 4; r++)
            run_batch($urandom_range(1, 40), $urandom_range(0, 1023), $urandom_range(1, 30),
                      1'($urandom_range(0, 1)), 1'b1, 0);
        run_batch(64, 100, 5, 1'b0, 1'b1, 10);
        @(negedge clk);
        check_all_zero("after_abort");
        run_batch(9, 200, 12, 1'b0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
